sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sfifo_mem.sv | 26 ++
 rtl/sync_fifo.sv | 112 +++++++++++
 tb/tb_sync_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry, pointer/count type and shared helper for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

  // Wide enough for pointers that wrap modulo 2*DEPTH and for a count of 0..DEPTH.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic logic sticky_next(input logic set, input logic clr, input logic cur);
    return set | (~clr & cur);
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: single-clock storage array with synchronous write and combinational read, no reset.
module sfifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered count, threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is registered.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Status flags decode only the registered count, so no flag depends on w_en/r_en.
  always_comb begin
    full         = (r_count == CNT_FULL);
    empty        = (r_count == CNT_ZERO);
    almost_full  = (r_count >= af_thresh);
    almost_empty = (r_count <= ae_thresh);
    w_wr_acc     = w_en && !full;
    w_rd_acc     = r_en && !empty;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= CNT_ZERO;
      r_rd_ptr    <= CNT_ZERO;
      r_count     <= CNT_ZERO;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + CNT_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + CNT_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= sticky_next(w_en && full, clr_err, r_overflow);
      r_underflow <= sticky_next(r_en && empty, clr_err, r_underflow);
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  sfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown straight from storage; an empty FIFO presents zero.
  assign data_out = empty ? DATA_ZERO : w_rd_data;
`else
  logic [DATA_WIDTH-1:0] r_data_out;

  // Registered read data, updated only on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= DATA_ZERO;
    end else if (w_rd_acc) begin
      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: vector table, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          w_en      = 1'b0;
  logic          r_en      = 1'b0;
  logic          clr_err   = 1'b0;
  logic [DW-1:0] data_in   = 8'h00;
  ptr_t          af_thresh = 9'd0;
  ptr_t          ae_thresh = 9'd1;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_udf  = 1'b0;

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       re;
    logic       clr;
    logic [8:0] cnt;
    logic       emp;
    logic       ae;
    logic       udf;
    logic [7:0] dstd;
    logic [7:0] dfw;
  } vec_t;
  vec_t tbl[9];

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= int'(af_thresh)));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= int'(ae_thresh)));
    chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic cycle(input logic we, input logic [7:0] din, input logic re, input logic clr);
    int n;
    n = q.size();
    w_en = we; data_in = din; r_en = re; clr_err = clr;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    if (re && n != 0) m_dout = q.pop_front();
    if (we && n != DEPTH) q.push_back(din);
    m_ovf = (we && n == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = (re && n == 0) ? 1'b1 : (clr ? 1'b0 : m_udf);
    check_all("cyc");
  endtask

  // Asynchronous reset checked before any clock edge, released just after an edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    check_all("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int writes;
    int cyc;

    tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 9'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA1};
    tbl[1] = '{1'b1, 8'hB2, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA1};
    tbl[2] = '{1'b1, 8'hC3, 1'b1, 1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 8'hA1, 8'hB2};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'd1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'hC3};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 9'd0, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h00};
    tbl[6] = '{1'b1, 8'hD4, 1'b1, 1'b0, 9'd1, 1'b0, 1'b1, 1'b1, 8'hC3, 8'hD4};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 9'd1, 1'b0, 1'b1, 1'b0, 8'hC3, 8'hD4};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 1'b1, 1'b0, 8'hC3, 8'hD4};

    // Power-on reset with af_thresh==0 so almost_full reads 1 in reset.
    #1;
    check_all("por");
    chk("por.afull_thr0", 32'(almost_full), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    af_thresh = 9'd3;
    ae_thresh = 9'd1;
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].we, tbl[i].din, tbl[i].re, tbl[i].clr);
      chk("tbl.count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl.empty", 32'(empty), 32'(tbl[i].emp));
      chk("tbl.aempty", 32'(almost_empty), 32'(tbl[i].ae));
      chk("tbl.udf", 32'(underflow), 32'(tbl[i].udf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("tbl.dout", 32'(data_out), 32'(tbl[i].dfw));
`else
      chk("tbl.dout", 32'(data_out), 32'(tbl[i].dstd));
`endif
    end

    // Fill to full with threshold crossings, then overflow.
    af_thresh = 9'd200;
    ae_thresh = 9'd10;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 198) chk("afull@199", 32'(almost_full), 32'd0);
      if (i == 199) chk("afull@200", 32'(almost_full), 32'd1);
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd256);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf.set", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd256);

    // Full with both requests: read wins, 0xEE must not be stored.
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("both_full.count", 32'(count), 32'd255);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", 32'(overflow), 32'd0);

    // Drain remaining words in order with almost_empty crossings.
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (q.size() == 11) chk("aempty@11", 32'(almost_empty), 32'd0);
      if (q.size() == 10) chk("aempty@10", 32'(almost_empty), 32'd1);
    end
    chk("drain.empty", 32'(empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain.last", 32'(data_out), 32'hFF);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf.set", 32'(underflow), 32'd1);

    // Empty with both requests: write wins.
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("both_empty.count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("both_empty.dout", 32'(data_out), 32'h77);
`else
    chk("both_empty.dout", 32'(data_out), 32'hFF);
`endif
    for (int i = 1; i < 100; i++) cycle(1'b1, 8'(i + 16), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("both_100.count", 32'(count), 32'd100);

    // Single write into an empty FIFO: FWFT shows it as empty falls.
    do_reset();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5.empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("a5.dout", 32'(data_out), 32'hA5);
`else
    chk("a5.dout", 32'(data_out), 32'h00);
`endif

    // Random traffic long enough for both pointers to wrap past 2*DEPTH.
    af_thresh = 9'd128;
    ae_thresh = 9'd64;
    do_reset();
    writes = 0;
    cyc = 0;
    while (writes < 600 && cyc < 20000) begin
      logic we, re, clr;
      we  = ($urandom_range(0, 3) != 0);
      re  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if (we && q.size() != DEPTH) writes++;
      cycle(we, 8'($urandom), re, clr);
      cyc++;
    end
    chk("rand.writes", 32'(writes), 32'd600);

    // Reset in the middle of a burst.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
    do_reset();
    w_en = 1'b0; r_en = 1'b0;
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
